match_sequencer: RTL and testbench

Time-multiplexes one shared template-score engine across all 17 corner templates: 13 ranks and 4 suits. A single engine replaces 17 parallel scorers. Sits between the corner-crop capture logic and the card-decode/display logic. On each start it issues templates in a fixed order and tracks the running minimum (best) score per class. It then emits a 6-bit card code plus rank and suit match percentages.

---
 rtl/card_pkg.sv | 47 ++++
 rtl/score_to_percent.sv | 27 ++
 rtl/match_sequencer.sv | 146 ++++++++++++++
 tb/tb_match_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared constants, state encoding and code helpers for the corner-template
// match sequencer.
package card_pkg;

  localparam int CORNER_WIDTH = 28;
  localparam int RANK_HEIGHT  = 40;
  localparam int SUIT_HEIGHT  = 29;
  localparam int RANK_SIZE    = CORNER_WIDTH * RANK_HEIGHT;  // 1120 pixels
  localparam int SUIT_SIZE    = CORNER_WIDTH * SUIT_HEIGHT;  // 812 pixels

  localparam int SCORE_W = $clog2(RANK_SIZE);  // 11-bit mismatch count
  localparam int IDX_W   = 5;
  localparam int PCT_W   = 7;

  // Rank codes run ace=1 .. king=13; suit codes follow template order.
  localparam logic [3:0] RANK_NONE    = 4'd0;
  localparam logic [3:0] RANK_ACE     = 4'd1;
  localparam logic [3:0] RANK_KING    = 4'd13;
  localparam logic [1:0] SUIT_DIAMOND = 2'b00;
  localparam logic [1:0] SUIT_HEART   = 2'b01;
  localparam logic [1:0] SUIT_CLUB    = 2'b10;
  localparam logic [1:0] SUIT_SPADE   = 2'b11;

  // Templates 0..12 are ranks, 13..16 are suits.
  localparam logic [IDX_W-1:0] FIRST_SUIT_IDX = 5'd13;
  localparam logic [IDX_W-1:0] LAST_IDX       = 5'd16;

  localparam logic [SCORE_W-1:0] SCORE_WORST = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CALC  = 2'd3
  } state_t;

  // Template index of a rank template to its 4-bit rank code.
  function automatic logic [3:0] rank_code(input logic [IDX_W-1:0] idx);
    return 4'(idx + IDX_W'(RANK_ACE));
  endfunction

  // Template index of a suit template to its 2-bit suit code.
  function automatic logic [1:0] suit_code(input logic [IDX_W-1:0] idx);
    return 2'(idx - FIRST_SUIT_IDX);
  endfunction

endpackage

// File: rtl/score_to_percent.sv
// Converts a best mismatch count into a 0..100 match percentage for a
// template of SIZE pixels. Counts above SIZE clamp to 0 percent.
module score_to_percent
  import card_pkg::*;
#(
  parameter int SIZE = RANK_SIZE
) (
  input  logic [SCORE_W-1:0] score_i,
  output logic [PCT_W-1:0]   pct_o
);

  localparam logic [17:0] SIZE_W = 18'(SIZE);

  logic [17:0] prod;
  logic [17:0] quot;

  // 100 - floor(score*100/SIZE); the quotient test also covers score==SIZE.
  always_comb begin
    prod  = 18'(score_i) * 18'd100;
    quot  = prod / SIZE_W;
    pct_o = '0;
    if ((18'(score_i) <= SIZE_W) && (quot <= 18'd100)) begin
      pct_o = 7'd100 - quot[6:0];
    end
  end

endmodule

// File: rtl/match_sequencer.sv
// Issues the 17 corner templates to one shared scoring engine in order,
// keeps the lowest score per class (rank / suit) and publishes the card code
// with both match percentages.
//
// Engine handshake: eng_start_out pulses for one cycle with eng_template_out
// valid; eng_template_out then holds until the engine answers with a
// one-cycle eng_valid_in carrying eng_score_in. There is no backpressure; a
// missing answer is bounded by TIMEOUT_CYCLES and aborts the pass.
module match_sequencer
  import card_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  output logic               busy_out,
  output logic               eng_start_out,
  output logic [IDX_W-1:0]   eng_template_out,
  input  logic               eng_valid_in,
  input  logic [SCORE_W-1:0] eng_score_in,
  output logic [5:0]         card_map_out,
  output logic [PCT_W-1:0]   rank_score_out,
  output logic [PCT_W-1:0]   suit_score_out,
  output logic               valid_out,
  output logic               error_out,
  output logic [1:0]         state_dbg_out
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  // The counter reads 0 in the first WAIT cycle, so the abort decision is
  // taken one count early to land TIMEOUT_CYCLES cycles after ISSUE.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [TO_W-1:0]    to_cnt_q;
  logic [SCORE_W-1:0] best_rank_q;
  logic [SCORE_W-1:0] best_suit_q;
  logic [3:0]         rank_code_q;
  logic [1:0]         suit_code_q;
  logic               eng_start_q;
  logic               valid_q;
  logic               error_q;
  logic [5:0]         card_map_q;
  logic [PCT_W-1:0]   rank_pct_q;
  logic [PCT_W-1:0]   suit_pct_q;

  logic [PCT_W-1:0]   rank_pct;
  logic [PCT_W-1:0]   suit_pct;

  score_to_percent #(.SIZE(RANK_SIZE)) u_rank_pct (
    .score_i (best_rank_q),
    .pct_o   (rank_pct)
  );

  score_to_percent #(.SIZE(SUIT_SIZE)) u_suit_pct (
    .score_i (best_suit_q),
    .pct_o   (suit_pct)
  );

  // Sequencer FSM: issue, wait/track minimum, compute, with registered pulses.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      to_cnt_q    <= '0;
      best_rank_q <= SCORE_WORST;
      best_suit_q <= SCORE_WORST;
      rank_code_q <= RANK_NONE;
      suit_code_q <= SUIT_DIAMOND;
      eng_start_q <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      card_map_q  <= '0;
      rank_pct_q  <= '0;
      suit_pct_q  <= '0;
    end else begin
      eng_start_q <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_in) begin
            state_q     <= ISSUE;
            idx_q       <= '0;
            best_rank_q <= SCORE_WORST;
            best_suit_q <= SCORE_WORST;
            rank_code_q <= RANK_NONE;
            suit_code_q <= SUIT_DIAMOND;
            eng_start_q <= 1'b1;
          end
        end
        ISSUE: begin
          state_q  <= WAIT;
          to_cnt_q <= '0;
        end
        WAIT: begin
          if (eng_valid_in) begin
            // Strict compare keeps the lowest index on ties.
            if (idx_q < FIRST_SUIT_IDX) begin
              if (eng_score_in < best_rank_q) begin
                best_rank_q <= eng_score_in;
                rank_code_q <= rank_code(idx_q);
              end
            end else if (eng_score_in < best_suit_q) begin
              best_suit_q <= eng_score_in;
              suit_code_q <= suit_code(idx_q);
            end
            if (idx_q == LAST_IDX) begin
              state_q <= CALC;
            end else begin
              idx_q       <= idx_q + 5'd1;
              state_q     <= ISSUE;
              eng_start_q <= 1'b1;
            end
          end else if (to_cnt_q == TO_LAST) begin
            error_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        CALC: begin
          card_map_q <= {suit_code_q, rank_code_q};
          rank_pct_q <= rank_pct;
          suit_pct_q <= suit_pct;
          valid_q    <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_out         = (state_q != IDLE);
  assign eng_start_out    = eng_start_q;
  assign eng_template_out = idx_q;
  assign card_map_out     = card_map_q;
  assign rank_score_out   = rank_pct_q;
  assign suit_score_out   = suit_pct_q;
  assign valid_out        = valid_q;
  assign error_out        = error_q;
  assign state_dbg_out    = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: engine responder, table vectors, random passes
// against a min-search model, plus timeout, stray-input and reset sequences.
module tb_match_sequencer;

  localparam int TMO = 16;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic        busy_out;
  logic        eng_start_out;
  logic [4:0]  eng_template_out;
  logic        eng_valid_in;
  logic [10:0] eng_score_in;
  logic [5:0]  card_map_out;
  logic [6:0]  rank_score_out;
  logic [6:0]  suit_score_out;
  logic        valid_out;
  logic        error_out;
  logic [1:0]  state_dbg_out;

  logic        eng_v;
  logic        stray_v;
  assign eng_valid_in = eng_v | stray_v;

  match_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .start_in         (start_in),
    .busy_out         (busy_out),
    .eng_start_out    (eng_start_out),
    .eng_template_out (eng_template_out),
    .eng_valid_in     (eng_valid_in),
    .eng_score_in     (eng_score_in),
    .card_map_out     (card_map_out),
    .rank_score_out   (rank_score_out),
    .suit_score_out   (suit_score_out),
    .valid_out        (valid_out),
    .error_out        (error_out),
    .state_dbg_out    (state_dbg_out)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- shared state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [10:0] sc[17];
  int          eng_lat = 1;
  int          withhold_idx = -1;
  int          n_starts = 0;
  logic [4:0]  exp_q[$];
  logic [5:0]  last_map;
  logic [6:0]  last_rank;
  logic [6:0]  last_suit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- engine responder ----------------
  initial begin : engine
    int pend;
    int cur;
    pend = 0;
    cur = 0;
    eng_v = 1'b0;
    eng_score_in = '0;
    forever begin
      @(negedge clk_in);
      eng_v = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          eng_v = 1'b1;
          eng_score_in = sc[cur];
        end
      end
      if (eng_start_out === 1'b1) begin
        n_starts++;
        if (exp_q.size() > 0) check("tmpl_order", eng_template_out, exp_q.pop_front());
        else check("unexpected_eng_start", eng_start_out, 0);
        cur = int'(eng_template_out);
        if (cur != withhold_idx) pend = eng_lat;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int pct(input int best, input int size);
    if (best > size) return 0;
    return 100 - (best * 100) / size;
  endfunction

  task automatic model(output logic [5:0] m, output logic [6:0] rp, output logic [6:0] sp);
    int br, bs, rc, sc_code;
    br = 2047; bs = 2047; rc = 0; sc_code = 0;
    for (int i = 0; i < 13; i++) if (int'(sc[i]) < br) begin br = int'(sc[i]); rc = i + 1; end
    for (int i = 13; i < 17; i++) if (int'(sc[i]) < bs) begin bs = int'(sc[i]); sc_code = i - 13; end
    m  = 6'(sc_code * 16 + rc);
    rp = 7'(pct(br, 1120));
    sp = 7'(pct(bs, 812));
  endtask

  task automatic load(input int rbase, input int ridx, input int rmin,
                      input int sbase, input int sidx, input int smin);
    for (int i = 0; i < 13; i++) sc[i] = 11'(rbase);
    for (int i = 13; i < 17; i++) sc[i] = 11'(sbase);
    if (ridx >= 0) sc[ridx] = 11'(rmin);
    if (sidx >= 0) sc[sidx] = 11'(smin);
  endtask

  // ---------------- one full pass ----------------
  task automatic do_pass(input string tag, input int lat,
                         input logic [5:0] em, input logic [6:0] er, input logic [6:0] es,
                         input bit mid, input bit chain, input bit already_started);
    int k;
    int busy_bad;
    bit got;
    exp_q.delete();
    for (int i = 0; i < 17; i++) exp_q.push_back(5'(i));
    n_starts = 0;
    eng_lat = lat;
    withhold_idx = -1;
    if (!already_started) begin
      @(negedge clk_in);
      start_in = 1'b1;
    end
    k = 0; got = 1'b0; busy_bad = 0;
    while (k < 400 && !got) begin
      @(negedge clk_in);
      k++;
      start_in = (mid && k == 10);
      if (valid_out === 1'b1) got = 1'b1;
      else if (busy_out !== 1'b1) busy_bad++;
    end
    if (got && chain) start_in = 1'b1;
    check({tag, "_latency"}, k, 17 * (lat + 1) + 2);
    check({tag, "_busy_during"}, busy_bad, 0);
    check({tag, "_busy_at_valid"}, busy_out, 0);
    check({tag, "_card_map"}, card_map_out, em);
    check({tag, "_rank_pct"}, rank_score_out, er);
    check({tag, "_suit_pct"}, suit_score_out, es);
    check({tag, "_eng_starts"}, n_starts, 17);
    last_map = em; last_rank = er; last_suit = es;
    if (!chain) begin
      @(negedge clk_in);
      check({tag, "_valid_pulse"}, valid_out, 0);
      check({tag, "_hold_map"}, card_map_out, em);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int rbase, ridx, rmin, sbase, sidx, smin, lat;
    bit mid, chain;
    logic [5:0] em;
    logic [6:0] er, es;
  } vec_t;

  vec_t vecs[5];

  initial begin : main
    logic [5:0] m;
    logic [6:0] rp, sp;
    int k;
    bit saw_valid;

    vecs[0] = '{500, 6, 100, 500, 15, 50, 1, 1'b0, 1'b0, 6'b100111, 7'd92, 7'd94};
    vecs[1] = '{300, -1, 0, 200, -1, 0, 2, 1'b1, 1'b1, 6'b000001, 7'd74, 7'd76};
    vecs[2] = '{700, 12, 0, 1023, -1, 0, 3, 1'b0, 1'b0, 6'b001101, 7'd100, 7'd0};
    vecs[3] = '{1200, 0, 5, 800, 16, 0, 1, 1'b0, 1'b0, 6'b110001, 7'd100, 7'd100};
    vecs[4] = '{1120, 12, 1119, 812, 14, 811, 4, 1'b0, 1'b0, 6'b011101, 7'd1, 7'd1};

    // clock / reset
    rst_in = 1'b1; start_in = 1'b0; stray_v = 1'b0;
    for (int i = 0; i < 17; i++) sc[i] = '0;
    #12;
    check("rst_busy", busy_out, 0);
    check("rst_eng_start", eng_start_out, 0);
    check("rst_template", eng_template_out, 0);
    check("rst_card_map", card_map_out, 0);
    check("rst_rank", rank_score_out, 0);
    check("rst_suit", suit_score_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_error", error_out, 0);
    check("rst_state", state_dbg_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // table vectors
    for (int v = 0; v < 5; v++) begin
      load(vecs[v].rbase, vecs[v].ridx, vecs[v].rmin, vecs[v].sbase, vecs[v].sidx, vecs[v].smin);
      do_pass($sformatf("vec%0d", v), vecs[v].lat, vecs[v].em, vecs[v].er, vecs[v].es,
              vecs[v].mid, vecs[v].chain, (v > 0) && vecs[v-1].chain);
    end

    // randomized passes against the model
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 13; i++) sc[i] = 11'($urandom_range(0, 1300));
      for (int i = 13; i < 17; i++) sc[i] = 11'($urandom_range(0, 1000));
      model(m, rp, sp);
      do_pass($sformatf("rand%0d", r), $urandom_range(1, 4), m, rp, sp, 1'b0, 1'b0, 1'b0);
    end

    // stray engine strobe while idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      stray_v = 1'b1;
      check("stray_state_idle", state_dbg_out, 0);
      check("stray_no_eng_start", eng_start_out, 0);
      check("stray_no_valid", valid_out, 0);
    end
    @(negedge clk_in);
    stray_v = 1'b0;

    // engine withholds its answer on template 3
    for (int i = 0; i < 17; i++) sc[i] = 11'($urandom_range(0, 800));
    exp_q.delete();
    for (int i = 0; i < 17; i++) exp_q.push_back(5'(i));
    n_starts = 0; eng_lat = 1; withhold_idx = 3;
    @(negedge clk_in);
    start_in = 1'b1;
    k = 0; saw_valid = 1'b0;
    while (k < 200) begin
      @(negedge clk_in);
      k++;
      start_in = 1'b0;
      if (valid_out === 1'b1) saw_valid = 1'b1;
      if (error_out === 1'b1) break;
    end
    check("tmo_error_cycle", k, 1 + 3 * 2 + TMO);
    check("tmo_no_valid", saw_valid, 0);
    check("tmo_eng_starts", n_starts, 4);
    @(negedge clk_in);
    check("tmo_state_idle", state_dbg_out, 0);
    check("tmo_error_pulse", error_out, 0);
    check("tmo_busy_low", busy_out, 0);
    check("tmo_hold_map", card_map_out, last_map);
    check("tmo_hold_rank", rank_score_out, last_rank);
    check("tmo_hold_suit", suit_score_out, last_suit);
    withhold_idx = -1;
    exp_q.delete();

    // reset in the WAIT of template 9
    for (int i = 0; i < 17; i++) sc[i] = 11'($urandom_range(0, 1200));
    exp_q.delete();
    for (int i = 0; i < 17; i++) exp_q.push_back(5'(i));
    eng_lat = 2;
    @(negedge clk_in);
    start_in = 1'b1;
    for (int c = 1; c <= 29; c++) begin
      @(negedge clk_in);
      start_in = 1'b0;
    end
    check("pre_rst_template", eng_template_out, 9);
    check("pre_rst_state_wait", state_dbg_out, 2);
    rst_in = 1'b1;
    #1;
    check("mid_rst_busy", busy_out, 0);
    check("mid_rst_eng_start", eng_start_out, 0);
    check("mid_rst_template", eng_template_out, 0);
    check("mid_rst_card_map", card_map_out, 0);
    check("mid_rst_rank", rank_score_out, 0);
    check("mid_rst_suit", suit_score_out, 0);
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_error", error_out, 0);
    check("mid_rst_state", state_dbg_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_in);
      check("post_rst_no_valid", valid_out, 0);
      check("post_rst_no_error", error_out, 0);
    end
    for (int i = 0; i < 17; i++) sc[i] = 11'($urandom_range(0, 1200));
    model(m, rp, sp);
    do_pass("after_rst", 1, m, rp, sp, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
